// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 control units: FSM states,
// instruction classes, ALU operation codes and datapath select values.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_ADDR, S_MEM_LD,
        S_WB_MEM, S_MEM_ST, S_EXEC_CBZ, S_EXEC_B, S_HALT, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_B, CLS_HLT, CLS_ILL
    } instr_cls_t;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_ORR   = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_PASSB = 4'd7;
    localparam logic [3:0] ALU_NOR   = 4'd12;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_HLT  = 11'b11010100010;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic       A_SEL_PC   = 1'b0;
    localparam logic       A_SEL_RN   = 1'b1;
    localparam logic [1:0] B_SEL_REG  = 2'd0;
    localparam logic [1:0] B_SEL_FOUR = 2'd1;
    localparam logic [1:0] B_SEL_IMM  = 2'd2;
    localparam logic       ADDR_PC    = 1'b0;
    localparam logic       ADDR_ALU   = 1'b1;
    localparam logic       PC_SEQ     = 1'b0;
    localparam logic       PC_BRANCH  = 1'b1;
    localparam logic       WB_ALU     = 1'b0;
    localparam logic       WB_MDR     = 1'b1;
    localparam logic       R2_RM      = 1'b0;
    localparam logic       R2_RT      = 1'b1;

endpackage

// File: rtl/legv8_opcode_decode.sv
// Maps the 11-bit LEGv8 opcode field to an instruction class and ALU op.
// HLT is classified by opcode only; the caller qualifies the low operand bits.
module legv8_opcode_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] i_opcode,
    output instr_cls_t  o_cls,
    output logic [3:0]  o_alu_ctr
);

    always_comb begin
        o_cls     = CLS_ILL;
        o_alu_ctr = ALU_ADD;
        if (i_opcode == OP_ADD) begin
            o_cls = CLS_R;
        end else if (i_opcode == OP_SUB) begin
            o_cls     = CLS_R;
            o_alu_ctr = ALU_SUB;
        end else if (i_opcode == OP_AND) begin
            o_cls     = CLS_R;
            o_alu_ctr = ALU_AND;
        end else if (i_opcode == OP_ORR) begin
            o_cls     = CLS_R;
            o_alu_ctr = ALU_ORR;
        end else if (i_opcode == OP_LDUR) begin
            o_cls = CLS_LD;
        end else if (i_opcode == OP_STUR) begin
            o_cls = CLS_ST;
        end else if (i_opcode[10:3] == OP_CBZ) begin
            o_cls     = CLS_CBZ;
            o_alu_ctr = ALU_PASSB;
        end else if (i_opcode[10:5] == OP_B) begin
            o_cls = CLS_B;
        end else if (i_opcode == OP_HLT) begin
            o_cls = CLS_HLT;
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback
// sequencing with a bounded memory-wait timeout into a sticky ERROR state.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_alu_zero,
    input  logic        i_mem_ready,
    output logic [3:0]  o_alu_ctr,
    output logic        o_alu_a_sel,
    output logic [1:0]  o_alu_b_sel,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_addr_sel,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_pc_src,
    output logic        o_reg_write,
    output logic        o_wb_sel,
    output logic        o_reg2_sel,
    output logic        o_busy,
    output logic        o_error
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W:0] TMO = MEM_TIMEOUT[CNT_W:0];

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    instr_cls_t       w_cls;
    logic [3:0]       w_alu_op;
    logic             w_mem_wait;
    logic             w_timeout;

    legv8_opcode_decode u_dec (
        .i_opcode  (i_instr[31:21]),
        .o_cls     (w_cls),
        .o_alu_ctr (w_alu_op)
    );

    assign w_mem_wait = (r_state inside {S_FETCH, S_MEM_LD, S_MEM_ST}) && !i_mem_ready;
    // Fires on the wait cycle that would bring the counter to MEM_TIMEOUT.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait &&
                        (({1'b0, r_wait_cnt} + 1'b1) == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_mem_wait ? r_wait_cnt + 1'b1 : '0;
            case (r_state)
                S_IDLE:      r_state <= S_FETCH;
                S_FETCH:     if (w_timeout) r_state <= S_ERROR;
                             else if (i_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_cls)
                        CLS_R:          r_state <= S_EXEC_R;
                        CLS_LD, CLS_ST: r_state <= S_EXEC_ADDR;
                        CLS_CBZ:        r_state <= S_EXEC_CBZ;
                        CLS_B:          r_state <= S_EXEC_B;
                        CLS_HLT:        r_state <= (i_instr[20:0] == '0) ? S_HALT : S_ERROR;
                        default:        r_state <= S_ERROR;
                    endcase
                end
                S_EXEC_R:    r_state <= S_WB_R;
                S_WB_R:      r_state <= S_FETCH;
                S_EXEC_ADDR: r_state <= (w_cls == CLS_LD) ? S_MEM_LD : S_MEM_ST;
                S_MEM_LD:    if (w_timeout) r_state <= S_ERROR;
                             else if (i_mem_ready) r_state <= S_WB_MEM;
                S_WB_MEM:    r_state <= S_FETCH;
                S_MEM_ST:    if (w_timeout) r_state <= S_ERROR;
                             else if (i_mem_ready) r_state <= S_FETCH;
                S_EXEC_CBZ:  r_state <= S_FETCH;
                S_EXEC_B:    r_state <= S_FETCH;
                S_HALT:      r_state <= S_HALT;
                default:     r_state <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        o_alu_ctr      = ALU_ADD;
        o_alu_a_sel    = A_SEL_PC;
        o_alu_b_sel    = B_SEL_REG;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = ADDR_PC;
        o_ir_write     = 1'b0;
        o_pc_write     = 1'b0;
        o_pc_src       = PC_SEQ;
        o_reg_write    = 1'b0;
        o_wb_sel       = WB_ALU;
        o_reg2_sel     = R2_RM;
        o_busy         = !(r_state inside {S_IDLE, S_HALT, S_ERROR});
        o_error        = (r_state == S_ERROR);
        case (r_state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_b_sel = B_SEL_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_EXEC_R: begin
                o_alu_a_sel = A_SEL_RN;
                o_alu_ctr   = w_alu_op;
            end
            S_WB_R:      o_reg_write = 1'b1;
            S_EXEC_ADDR: begin
                o_alu_a_sel = A_SEL_RN;
                o_alu_b_sel = B_SEL_IMM;
            end
            S_MEM_LD: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = ADDR_ALU;
            end
            S_WB_MEM: begin
                o_reg_write = 1'b1;
                o_wb_sel    = WB_MDR;
            end
            S_MEM_ST: begin
                o_mem_req      = 1'b1;
                o_mem_we       = 1'b1;
                o_mem_addr_sel = ADDR_ALU;
                o_reg2_sel     = R2_RT;
            end
            S_EXEC_CBZ: begin
                o_reg2_sel = R2_RT;
                o_alu_ctr  = ALU_PASSB;
                o_pc_write = i_alu_zero;
                o_pc_src   = PC_BRANCH;
            end
            S_EXEC_B: begin
                o_pc_write = 1'b1;
                o_pc_src   = PC_BRANCH;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: a per-instruction plan of expected output
// vectors is built from the instruction semantics and replayed cycle by cycle.
module tb_legv8_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] alu_ctr;
        logic       a_sel;
        logic [1:0] b_sel;
        logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
        logic       reg_write, wb_sel, reg2_sel, busy, error;
    } outv_t;

    typedef struct {
        logic        rdy;
        logic        zero;
        logic        ld;
        logic [31:0] ins;
        outv_t       exp;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_instr = 32'h0;
    logic        i_alu_zero = 1'b0;
    logic        i_mem_ready = 1'b0;
    logic [3:0]  o_alu_ctr;
    logic        o_alu_a_sel;
    logic [1:0]  o_alu_b_sel;
    logic        o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_write, o_pc_write, o_pc_src;
    logic        o_reg_write, o_wb_sel, o_reg2_sel, o_busy, o_error;
    outv_t       obs;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;
    step_t plan[$];

    legv8_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_instr(i_instr), .i_alu_zero(i_alu_zero),
        .i_mem_ready(i_mem_ready), .o_alu_ctr(o_alu_ctr), .o_alu_a_sel(o_alu_a_sel),
        .o_alu_b_sel(o_alu_b_sel), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr_sel(o_mem_addr_sel), .o_ir_write(o_ir_write), .o_pc_write(o_pc_write),
        .o_pc_src(o_pc_src), .o_reg_write(o_reg_write), .o_wb_sel(o_wb_sel),
        .o_reg2_sel(o_reg2_sel), .o_busy(o_busy), .o_error(o_error)
    );

    assign obs = {o_alu_ctr, o_alu_a_sel, o_alu_b_sel, o_mem_req, o_mem_we, o_mem_addr_sel,
                  o_ir_write, o_pc_write, o_pc_src, o_reg_write, o_wb_sel, o_reg2_sel,
                  o_busy, o_error};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outv_t v_busy();
        outv_t v = '0;
        v.alu_ctr = 4'd2;
        v.busy    = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_idle();
        outv_t v = '0;
        v.alu_ctr = 4'd2;
        return v;
    endfunction

    function automatic outv_t v_err();
        outv_t v = v_idle();
        v.error = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_fetch(input logic rdy);
        outv_t v = v_busy();
        v.mem_req  = 1'b1;
        v.b_sel    = 2'd1;
        v.ir_write = rdy;
        v.pc_write = rdy;
        return v;
    endfunction

    task automatic push(input logic rdy, input logic zero, input logic ld,
                        input logic [31:0] ins, input outv_t exp);
        step_t s;
        s.rdy = rdy; s.zero = zero; s.ld = ld; s.ins = ins; s.exp = exp;
        plan.push_back(s);
    endtask

    task automatic check(input string tag, input outv_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d instr=%h got=%h exp=%h", tag, n_step, i_instr, obs, exp);
        end
    endtask

    // Expected behaviour of one instruction, from its fetch through its last cycle.
    task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic zero);
        logic [10:0] opc;
        int          kind;
        logic [3:0]  op;
        outv_t       v;
        opc  = ins[31:21];
        kind = 6;
        op   = 4'd2;
        if (opc == 11'b10001011000)      begin kind = 0; op = 4'd2; end
        else if (opc == 11'b11001011000) begin kind = 0; op = 4'd6; end
        else if (opc == 11'b10001010000) begin kind = 0; op = 4'd0; end
        else if (opc == 11'b10101010000) begin kind = 0; op = 4'd1; end
        else if (opc == 11'b11111000010) kind = 1;
        else if (opc == 11'b11111000000) kind = 2;
        else if (ins[31:24] == 8'b10110100) kind = 3;
        else if (ins[31:26] == 6'b000101)   kind = 4;
        else if (ins == 32'hD4400000)       kind = 5;
        for (int i = 0; i < fw; i++) push(1'b0, rb(), 1'b0, ins, v_fetch(1'b0));
        push(1'b1, rb(), 1'b0, ins, v_fetch(1'b1));
        push(rb(), rb(), 1'b1, ins, v_busy());
        case (kind)
            0: begin
                v = v_busy(); v.a_sel = 1'b1; v.alu_ctr = op;
                push(rb(), rb(), 1'b0, ins, v);
                v = v_busy(); v.reg_write = 1'b1;
                push(rb(), rb(), 1'b0, ins, v);
            end
            1, 2: begin
                v = v_busy(); v.a_sel = 1'b1; v.b_sel = 2'd2;
                push(rb(), rb(), 1'b0, ins, v);
                v = v_busy(); v.mem_req = 1'b1; v.addr_sel = 1'b1;
                if (kind == 2) begin v.mem_we = 1'b1; v.reg2_sel = 1'b1; end
                for (int i = 0; i < mw; i++) push(1'b0, rb(), 1'b0, ins, v);
                push(1'b1, rb(), 1'b0, ins, v);
                if (kind == 1) begin
                    v = v_busy(); v.reg_write = 1'b1; v.wb_sel = 1'b1;
                    push(rb(), rb(), 1'b0, ins, v);
                end
            end
            3: begin
                v = v_busy(); v.reg2_sel = 1'b1; v.alu_ctr = 4'd7;
                v.pc_src = 1'b1; v.pc_write = zero;
                push(rb(), zero, 1'b0, ins, v);
            end
            4: begin
                v = v_busy(); v.pc_write = 1'b1; v.pc_src = 1'b1;
                push(rb(), rb(), 1'b0, ins, v);
            end
            5: for (int i = 0; i < 3; i++) push(rb(), rb(), 1'b0, ins, v_idle());
            default: for (int i = 0; i < 3; i++) push(rb(), rb(), 1'b0, ins, v_err());
        endcase
    endtask

    task automatic run_plan(input string tag);
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            i_mem_ready = s.rdy;
            i_alu_zero  = s.zero;
            if (s.ld) i_instr = s.ins;
            #1;
            n_step++;
            check(tag, s.exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("reset_hold", v_idle());
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_reset", v_idle());
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: return {11'b10001011000, r[20:0]};
            1: return {11'b11001011000, r[20:0]};
            2: return {11'b10001010000, r[20:0]};
            3: return {11'b10101010000, r[20:0]};
            4: return {11'b11111000010, r[20:0]};
            5: return {11'b11111000000, r[20:0]};
            6: return {8'b10110100, r[23:0]};
            default: return {6'b000101, r[25:0]};
        endcase
    endfunction

    initial begin
        logic [31:0] st;
        outv_t       v;
        #3 check("reset_state", v_idle());
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_reset", v_idle());

        build(32'h8B020023, 0, 0, 1'b0);
        run_plan("add");
        build(32'hCB020023, 0, 0, 1'b0);
        build(32'hAA020023, 1, 0, 1'b0);
        build(32'h8A020023, 0, 0, 1'b0);
        run_plan("sub_orr_and");
        build({11'b11111000010, 9'd8, 2'b00, 5'd2, 5'd1}, 0, 3, 1'b0);
        run_plan("ldur_wait3");
        build({8'b10110100, 19'd4, 5'd3}, 0, 0, 1'b1);
        build({8'b10110100, 19'd4, 5'd3}, 0, 0, 1'b0);
        run_plan("cbz");
        build({6'b000101, 26'd16}, 2, 0, 1'b0);
        build({11'b11111000000, 9'd16, 2'b00, 5'd2, 5'd4}, 0, 2, 1'b0);
        run_plan("b_stur");

        for (int k = 0; k < 40; k++) begin
            build(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run_plan("random");
        end
        build(32'hD4400000, 0, 0, 1'b0);
        run_plan("halt");

        do_reset();
        build(32'hFFFFFFFF, 0, 0, 1'b0);
        run_plan("illegal");
        do_reset();
        build({11'b11010100010, 21'd1}, 0, 0, 1'b0);
        run_plan("hlt_bad_operand");

        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, rb(), 1'b0, 32'h0, v_fetch(1'b0));
        for (int i = 0; i < 3; i++) push(rb(), rb(), 1'b0, 32'h0, v_err());
        run_plan("fetch_timeout");

        do_reset();
        st = {11'b11111000000, 9'd0, 2'b00, 5'd1, 5'd2};
        push(1'b1, 1'b0, 1'b0, st, v_fetch(1'b1));
        push(1'b0, 1'b0, 1'b1, st, v_busy());
        v = v_busy(); v.a_sel = 1'b1; v.b_sel = 2'd2;
        push(1'b0, 1'b0, 1'b0, st, v);
        v = v_busy(); v.mem_req = 1'b1; v.mem_we = 1'b1; v.addr_sel = 1'b1; v.reg2_sel = 1'b1;
        push(1'b0, 1'b0, 1'b0, st, v);
        run_plan("stur_wait");
        #2 rst_n = 1'b0;
        #1 check("async_reset_drop", v_idle());
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_async", v_idle());
        push(1'b1, 1'b0, 1'b0, st, v_fetch(1'b1));
        run_plan("fetch_after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Multi-cycle LEGv8 control FSM. It sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- It drives the 64-bit ALU's 4-bit operation code and operand selects, and consumes the ALU's Zero flag to resolve CBZ.
- It sits between the shared instruction/data memory handshake and the datapath (PC, IR, register file, ALU, MDR).
- The block is the producer side of the ALU control interface.

Parameters:
- MEM_TIMEOUT, 255, cycles to wait for mem_ready before entering ERROR; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  IR contents; valid from the cycle after ir_write
- alu_zero  in  1  ALU Zero flag
- mem_ready  in  1  memory completes the request this cycle
- alu_ctr  out  4  ALU op code: 0 AND, 1 ORR, 2 ADD, 6 SUB, 7 PASS-B, 12 NOR
- alu_a_sel  out  1  ALU A source: 0 PC, 1 reg Rn
- alu_b_sel  out  2  ALU B source: 0 reg Rm/Rt, 1 constant 4, 2 sign-extended D-format immediate
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier on mem_req
- mem_addr_sel  out  1  address source: 0 PC, 1 ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 ALU result (PC+4), 1 branch target
- reg_write  out  1  register file write enable
- wb_sel  out  1  writeback source: 0 ALUOut, 1 MDR
- reg2_sel  out  1  read port 2 index: 0 Rm, 1 Rt
- busy  out  1  high in every state except IDLE, HALT, ERROR
- error  out  1  sticky: illegal opcode or memory timeout

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE and the timeout counter clears.
  - All strobes (mem_req, mem_we, ir_write, pc_write, reg_write) are 0.
  - alu_ctr = 2; all selects = 0; busy = 0; error = 0.
  - IDLE moves to FETCH on the first clock after rst_n deasserts.
- Outputs are Moore, decoded from the state register. The only Mealy terms are the mem_ready-gated strobes and the alu_zero-gated pc_write, as listed below.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - alu_a_sel = 0, alu_b_sel = 1, alu_ctr = 2 (PC+4).
  - Hold while mem_ready = 0.
  - On mem_ready = 1, in the same cycle: ir_write = 1, pc_write = 1, pc_src = 0. Next state is DECODE.
- DECODE: one cycle, no strobes. Classify instr[31:21]:
  - 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR → EXEC_R.
  - 11111000010 LDUR, 11111000000 STUR → EXEC_ADDR.
  - instr[31:24] = 10110100 (CBZ) → EXEC_CBZ.
  - instr[31:26] = 000101 (B) → EXEC_B.
  - instr = 32'hD4400000 (HLT) → HALT.
  - Any other encoding → ERROR.
- EXEC_R:
  - alu_a_sel = 1, alu_b_sel = 0, reg2_sel = 0.
  - alu_ctr per opcode: ADD 2, SUB 6, AND 0, ORR 1.
  - Next state is WB_R.
- WB_R: reg_write = 1, wb_sel = 0. Next state is FETCH.
- EXEC_ADDR:
  - alu_a_sel = 1, alu_b_sel = 2, alu_ctr = 2.
  - Next state is MEM_LD or MEM_ST.
- MEM_LD: mem_req = 1, mem_we = 0, mem_addr_sel = 1. Hold until mem_ready, then go to WB_MEM.
- WB_MEM: reg_write = 1, wb_sel = 1. Next state is FETCH.
- MEM_ST: mem_req = 1, mem_we = 1, mem_addr_sel = 1, reg2_sel = 1. Hold until mem_ready, then go to FETCH.
- EXEC_CBZ:
  - reg2_sel = 1, alu_b_sel = 0, alu_ctr = 7 (PASS-B).
  - pc_write = alu_zero, pc_src = 1.
  - Next state is FETCH regardless of the branch outcome.
- EXEC_B: pc_write = 1, pc_src = 1. Next state is FETCH.
- HALT: terminal. busy = 0, all strobes 0. Exit only by reset.
- ERROR: terminal. error = 1, all strobes 0. Exit only by reset.
- Memory wait states:
  - The counter increments each cycle with mem_req high and mem_ready low, and clears on mem_ready.
  - If MEM_TIMEOUT ≠ 0 and the counter reaches MEM_TIMEOUT, go to ERROR with no strobes asserted in that cycle.
  - mem_req, mem_we and mem_addr_sel stay stable throughout a wait.
- At most one of ir_write, reg_write and pc_write (FETCH excepted) is asserted per cycle. No write strobe ever asserts in DECODE.
- Reset mid-access: all outputs drop asynchronously. The memory must tolerate mem_req falling without mem_ready.
- Cycle counts with zero wait: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum;
  - ALU code constants (ALU_AND = 0, ALU_ORR = 1, ALU_ADD = 2, ALU_SUB = 6, ALU_PASSB = 7, ALU_NOR = 12);
  - opcode constants;
  - select encodings.
- One sub-module, legv8_opcode_decode: combinational mapping from instr[31:21] to an instruction class and alu_ctr. It is shared with the future pipelined control unit.

Test Plan:
- ADD X3,X1,X2 (8B020023), mem_ready immediate:
  - FETCH drives alu_ctr = 2, alu_b_sel = 1, ir_write = pc_write = 1;
  - EXEC_R drives alu_ctr = 2;
  - WB_R drives reg_write = 1;
  - back in FETCH on cycle 5.
- SUB then ORR then AND: EXEC_R alu_ctr equals 6, 1, 0 respectively.
- LDUR with mem_ready delayed 3 cycles in MEM_LD:
  - mem_req, mem_addr_sel = 1 held stable for 4 cycles;
  - WB_MEM wb_sel = 1, reg_write = 1;
  - total 8 cycles.
- CBZ with alu_zero = 1: pc_write = 1, pc_src = 1, alu_ctr = 7. Repeated with alu_zero = 0: pc_write = 0. Both return to FETCH.
- Illegal instr 32'hFFFFFFFF: ERROR after DECODE, error = 1, busy = 0, no strobes thereafter. Memory never ready with MEM_TIMEOUT = 4: ERROR after 4 wait cycles.
- rst_n asserted while MEM_ST is waiting: mem_req and mem_we drop immediately, without a clock edge. After release: IDLE, then FETCH, with error = 0.
